// File: rtl/hazard_pkg.sv
// Shared widths, FSM encoding and control-bundle type for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int TO_W       = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_FLUSH = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic freeze_pc;
    logic freeze_ifid;
    logic freeze_idex;
    logic flush_ifid;
    logic flush_idex;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE      = '0;
  localparam ctrl_t CTRL_MEM_STALL = '{freeze_pc: 1'b1, freeze_ifid: 1'b1, freeze_idex: 1'b1,
                                       flush_ifid: 1'b0, flush_idex: 1'b0};

endpackage

// File: rtl/hazard_cmp.sv
// Load-use detector: the EX load's destination matches a source register the ID instruction reads.
// Purely combinational; register 0 is treated like any other register.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_src1_i,
  input  logic [REG_ADDR_W-1:0] id_src2_i,
  input  logic                  id_src1_vld_i,
  input  logic                  id_src2_vld_i,
  input  logic                  ex_load_i,
  input  logic                  ex_wb_en_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_i,
  output logic                  load_use_o
);

  logic hit1;
  logic hit2;

  assign hit1       = id_src1_vld_i && (id_src1_i == ex_dest_i);
  assign hit2       = id_src2_vld_i && (id_src2_i == ex_dest_i);
  assign load_use_o = ex_load_i && ex_wb_en_i && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stall/timeout, taken-branch flush and load-use bubble, zero-latency controls.
// Optional frozen-PC cycle counter enabled by defining HAZARD_PERF_CNT_EN; otherwise stall_cnt_o reads 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [REG_ADDR_W-1:0] id_src1_i,
  input  logic [REG_ADDR_W-1:0] id_src2_i,
  input  logic                  id_src1_vld_i,
  input  logic                  id_src2_vld_i,
  input  logic                  ex_load_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_i,
  input  logic                  ex_wb_en_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  input  logic                  stall_cnt_clr_i,
  output logic                  freeze_pc_o,
  output logic                  freeze_ifid_o,
  output logic                  freeze_idex_o,
  output logic                  flush_ifid_o,
  output logic                  flush_idex_o,
  output logic                  mem_err_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            mem_err_q;
  logic            timeout;
  logic            load_use;
  logic            mem_stall;
  ctrl_t           run_ctrl, ctrl, ctrl_out;
  state_e          run_next;

  hazard_cmp u_cmp (
    .id_src1_i     (id_src1_i),
    .id_src2_i     (id_src2_i),
    .id_src1_vld_i (id_src1_vld_i),
    .id_src2_vld_i (id_src2_vld_i),
    .ex_load_i     (ex_load_i),
    .ex_wb_en_i    (ex_wb_en_i),
    .ex_dest_i     (ex_dest_i),
    .load_use_o    (load_use)
  );

  assign mem_stall = mem_req_i && !mem_ready_i;

  // Normal hazard evaluation, shared by RUN and the MEM_WAIT completion cycle.
  always_comb begin
    run_ctrl = CTRL_NONE;
    run_next = ST_RUN;
    if (mem_stall) begin
      run_ctrl = CTRL_MEM_STALL;
      run_next = ST_MEM_WAIT;
    end else if (branch_taken_i) begin
      run_ctrl.flush_ifid = 1'b1;
      run_ctrl.flush_idex = 1'b1;
      run_next            = ST_BR_FLUSH;
    end else if (load_use) begin
      run_ctrl.freeze_pc   = 1'b1;
      run_ctrl.freeze_ifid = 1'b1;
      run_ctrl.flush_idex  = 1'b1;
    end
  end

  always_comb begin
    ctrl    = CTRL_NONE;
    state_d = ST_RUN;
    timeout = 1'b0;
    case (state_q)
      ST_RUN: begin
        ctrl    = run_ctrl;
        state_d = run_next;
      end
      ST_BR_FLUSH: begin
        if (mem_stall) begin
          ctrl    = CTRL_MEM_STALL;
          state_d = ST_MEM_WAIT;
        end else begin
          ctrl.flush_ifid = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          ctrl    = run_ctrl;
          state_d = run_next;
        end else begin
          ctrl = CTRL_MEM_STALL;
          if (to_q == TO_LAST) begin
            timeout = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end
      end
      default: begin
        ctrl    = CTRL_NONE;
        state_d = ST_RUN;
      end
    endcase
  end

  assign to_d = (state_q == ST_MEM_WAIT && state_d == ST_MEM_WAIT) ? to_q + TO_W'(1) : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_RUN;
      to_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      mem_err_q <= mem_err_q | timeout;
    end
  end

  // Controls are combinational from inputs, so reset must mask them explicitly.
  assign ctrl_out      = rst_n_i ? ctrl : CTRL_NONE;
  assign freeze_pc_o   = ctrl_out.freeze_pc;
  assign freeze_ifid_o = ctrl_out.freeze_ifid;
  assign freeze_idex_o = ctrl_out.freeze_idex;
  assign flush_ifid_o  = ctrl_out.flush_ifid;
  assign flush_idex_o  = ctrl_out.flush_idex;
  assign mem_err_o     = mem_err_q;
  assign state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr_i) begin
      stall_cnt_d = '0;
    end else if (ctrl_out.freeze_pc && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_stall_cnt_clr;
  assign unused_stall_cnt_clr = stall_cnt_clr_i;
  assign stall_cnt_o          = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Random and directed stimulus for hazard_ctrl, checked against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 5;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       id_src1, id_src2, ex_dest;
  logic             id_src1_vld, id_src2_vld, ex_load, ex_wb_en;
  logic             branch_taken, mem_req, mem_ready, stall_cnt_clr;
  logic             freeze_pc, freeze_ifid, freeze_idex, flush_ifid, flush_idex, mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: spec-level mode number (0 run, 1 branch refill, 2 memory wait).
  int m_state = 0;
  int m_wait  = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;
  bit e_fpc, e_fifid, e_fidex, e_flifid, e_flidex, e_errset;
  int e_next;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .id_src1_i       (id_src1),
    .id_src2_i       (id_src2),
    .id_src1_vld_i   (id_src1_vld),
    .id_src2_vld_i   (id_src2_vld),
    .ex_load_i       (ex_load),
    .ex_dest_i       (ex_dest),
    .ex_wb_en_i      (ex_wb_en),
    .branch_taken_i  (branch_taken),
    .mem_req_i       (mem_req),
    .mem_ready_i     (mem_ready),
    .stall_cnt_clr_i (stall_cnt_clr),
    .freeze_pc_o     (freeze_pc),
    .freeze_ifid_o   (freeze_ifid),
    .freeze_idex_o   (freeze_idex),
    .flush_ifid_o    (flush_ifid),
    .flush_idex_o    (flush_idex),
    .mem_err_o       (mem_err),
    .state_o         (state),
    .stall_cnt_o     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  task automatic set_idle();
    id_src1 = 3'd0; id_src2 = 3'd0; ex_dest = 3'd0;
    id_src1_vld = 1'b0; id_src2_vld = 1'b0; ex_load = 1'b0; ex_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; stall_cnt_clr = 1'b0;
  endtask

  task automatic model_eval();
    bit lu, stall_req;
    lu = ex_load && ex_wb_en &&
         ((id_src1_vld && id_src1 == ex_dest) || (id_src2_vld && id_src2 == ex_dest));
    stall_req = mem_req && !mem_ready;
    {e_fpc, e_fifid, e_fidex, e_flifid, e_flidex, e_errset} = '0;
    e_next = 0;
    if (m_state == 2 && !mem_ready) begin
      {e_fpc, e_fifid, e_fidex} = 3'b111;
      if (m_wait == MEM_TIMEOUT - 1) e_errset = 1'b1;
      else e_next = 2;
    end else if (m_state == 1 && !stall_req) begin
      e_flifid = 1'b1;
    end else if (stall_req) begin
      {e_fpc, e_fifid, e_fidex} = 3'b111;
      e_next = 2;
    end else if (branch_taken) begin
      {e_flifid, e_flidex} = 2'b11;
      e_next = 1;
    end else if (lu) begin
      {e_fpc, e_fifid, e_flidex} = 3'b111;
    end
  endtask

  task automatic model_commit();
    if (e_next == 2 && m_state == 2) m_wait++;
    else m_wait = 0;
    m_state = e_next;
    m_err   = m_err | e_errset;
`ifdef HAZARD_PERF_CNT_EN
    if (stall_cnt_clr) m_cnt = 0;
    else if (e_fpc && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`else
    m_cnt = 0;
`endif
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  // Called just after inputs are driven on the falling edge.
  task automatic sample();
    #2;
    model_eval();
    chk("freeze_pc",   32'(freeze_pc),   32'(e_fpc));
    chk("freeze_ifid", 32'(freeze_ifid), 32'(e_fifid));
    chk("freeze_idex", 32'(freeze_idex), 32'(e_fidex));
    chk("flush_ifid",  32'(flush_ifid),  32'(e_flifid));
    chk("flush_idex",  32'(flush_idex),  32'(e_flidex));
    chk("state",       32'(state),       32'(m_state));
    chk("mem_err",     32'(mem_err),     32'(m_err));
    chk("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_commit();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_cycle();
    sample();
    finish_cycle();
  endtask

  initial begin
    set_idle();
    mem_req = 1'b1; branch_taken = 1'b1;
    #2;
    chk("rst_ctrl",  32'({freeze_pc, freeze_ifid, freeze_idex, flush_ifid, flush_idex}), 32'(0));
    chk("rst_state", 32'(state), 32'(0));
    chk("rst_err",   32'(mem_err), 32'(0));
    chk("rst_cnt",   32'(stall_cnt), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();

    // Load-use on source 2, then the bubble cycle.
    ex_load = 1'b1; ex_wb_en = 1'b1; ex_dest = 3'd3; id_src2 = 3'd3; id_src2_vld = 1'b1; id_src1 = 3'd5;
    sample();
    chk("lu_ctrl", 32'({freeze_pc, freeze_ifid, flush_idex, freeze_idex}), 32'(4'b1110));
    finish_cycle();
    set_idle();
    sample();
    chk("lu_bubble", 32'({freeze_pc, freeze_ifid, freeze_idex, flush_ifid, flush_idex}), 32'(0));
    finish_cycle();

    // Register 0 is not exempt.
    ex_load = 1'b1; ex_wb_en = 1'b1; ex_dest = 3'd0; id_src1 = 3'd0; id_src1_vld = 1'b1;
    sample();
    chk("lu_r0", 32'(freeze_pc), 32'(1));
    finish_cycle();
    set_idle();

    // Taken branch: two-cycle flush pattern.
    branch_taken = 1'b1;
    sample();
    chk("br_n", 32'({flush_ifid, flush_idex, freeze_pc, freeze_ifid, freeze_idex}), 32'(5'b11000));
    finish_cycle();
    set_idle();
    sample();
    chk("br_n1_fl", 32'({flush_ifid, flush_idex}), 32'(2'b10));
    chk("br_n1_st", 32'(state), 32'(1));
    finish_cycle();
    sample();
    chk("br_n2_st", 32'(state), 32'(0));
    finish_cycle();

    // Memory stall of four cycles.
    stall_cnt_clr = 1'b1;
    run_cycle();
    set_idle();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("ms_frz", 32'({freeze_pc, freeze_ifid, freeze_idex}), 32'(3'b111));
      finish_cycle();
    end
    mem_ready = 1'b1;
    sample();
    chk("ms_rdy", 32'({freeze_pc, freeze_ifid, freeze_idex}), 32'(0));
`ifdef HAZARD_PERF_CNT_EN
    chk("ms_cnt", 32'(stall_cnt), 32'(4));
`else
    chk("ms_cnt", 32'(stall_cnt), 32'(0));
`endif
    finish_cycle();
    set_idle();

    // Memory never answers: abort after MEM_TIMEOUT wait cycles.
    mem_req = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) run_cycle();
    set_idle();
    sample();
    chk("to_err",   32'(mem_err), 32'(1));
    chk("to_state", 32'(state), 32'(0));
    finish_cycle();
    run_cycle();
    chk("to_sticky", 32'(mem_err), 32'(1));

    // Asynchronous reset during the second wait cycle.
    mem_req = 1'b1;
    run_cycle();
    run_cycle();
    sample();
    rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'(0));
    chk("ar_ctrl",  32'({freeze_pc, freeze_ifid, freeze_idex, flush_ifid, flush_idex}), 32'(0));
    chk("ar_cnt",   32'(stall_cnt), 32'(0));
    chk("ar_err",   32'(mem_err), 32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    set_idle();

    // Branch wins over a concurrent load-use.
    branch_taken = 1'b1; ex_load = 1'b1; ex_wb_en = 1'b1; ex_dest = 3'd6; id_src1 = 3'd6; id_src1_vld = 1'b1;
    sample();
    chk("br_lu", 32'({flush_ifid, flush_idex, freeze_pc}), 32'(3'b110));
    finish_cycle();
    set_idle();

    // Randomized traffic with alternating quick and slow memory phases.
    for (int i = 0; i < 800; i++) begin
      id_src1       = 3'($urandom_range(0, 3));
      id_src2       = 3'($urandom_range(0, 3));
      ex_dest       = 3'($urandom_range(0, 3));
      id_src1_vld   = 1'($urandom % 2);
      id_src2_vld   = 1'($urandom % 2);
      ex_load       = 1'($urandom % 2);
      ex_wb_en      = ($urandom % 4) != 0;
      branch_taken  = ($urandom % 6) == 0;
      mem_req       = ($urandom % 4) == 0;
      mem_ready     = ((i % 64) < 32) ? 1'($urandom % 2) : (($urandom % 10) == 0);
      stall_cnt_clr = ($urandom % 40) == 0;
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
